snake_game_ctrl: RTL and testbench

Top-level sequencer for the Snake game. It owns the game state machine and drives `gameStatus`, `dieFlash` and `addLength` into the `Snake` datapath. It generates the movement strobe, places the apple, detects eating and collisions from `Snake`'s `headX`/`headY`/`hitBody`/`hitWall` outputs, and keeps score. It sits between the input debouncers and `Snake`/VGA renderer.

---
 rtl/snake_game_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game sequencer for Snake. It runs the IDLE/PLAY/DIE/OVER
// state machine, generates the move strobe and the die blink, places apples
// with a 12-bit LFSR using rejection sampling, detects eating, and keeps score.
// Optional feature: define SNAKE_CTRL_SPEEDUP_EN to shorten the step period
// as the score grows. Without it the period is the constant TICK_DIV.
module snake_game_ctrl #(
  parameter int unsigned TICK_DIV  = 12_500_000,
  parameter int unsigned FLASH_CNT = 4,
  parameter int unsigned GRID_W    = 40,
  parameter int unsigned GRID_H    = 30,
  parameter int unsigned APPLE_X0  = 20,
  parameter int unsigned APPLE_Y0  = 15,
  parameter int unsigned TICK_STEP = 200_000,
  parameter int unsigned TICK_MIN  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_press,
  input  logic [5:0] headX,
  input  logic [5:0] headY,
  input  logic [6:0] bodyNum,
  input  logic       hitBody,
  input  logic       hitWall,
  output logic [1:0] gameStatus,
  output logic       moveTick,
  output logic       addLength,
  output logic       dieFlash,
  output logic [5:0] appleX,
  output logic [5:0] appleY,
  output logic [7:0] score
);

  localparam int unsigned CNT_W     = 24;
  localparam int unsigned DIE_TICKS = 2 * FLASH_CNT;
  localparam int unsigned DIE_W     = $clog2(DIE_TICKS + 1);
  localparam logic [11:0] LFSR_SEED = 12'hACE;

  // Encoding doubles as the gameStatus output code
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b10,
    ST_DIE  = 2'b11,
    ST_OVER = 2'b01
  } state_e;

  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIE_W-1:0]   die_cnt_q, die_cnt_d;
  logic [11:0]        lfsr_q, lfsr_d;
  logic               valid_q, valid_d;
  logic [5:0]         apple_x_q, apple_x_d;
  logic [5:0]         apple_y_q, apple_y_d;
  logic [7:0]         score_q, score_d;
  logic               move_q, move_d;
  logic               add_q, add_d;
  logic               flash_q, flash_d;

  logic               start_edge;
  logic               hit;
  logic               running;
  logic               tick;
  logic               eat;
  logic               apple_fits;
  logic [CNT_W-1:0]   period;

`ifdef SNAKE_CTRL_SPEEDUP_EN
  logic [CNT_W-1:0]   period_q, period_d;
  logic [29:0]        dec;
  logic [29:0]        diff;
  logic [CNT_W-1:0]   next_period;

  // Candidate period from the current score, clamped to the floor
  always_comb begin
    dec  = 30'(score_q[7:2]) * 30'(TICK_STEP);
    diff = 30'(TICK_DIV) - dec;
    if (dec >= 30'(TICK_DIV)) begin
      next_period = CNT_W'(TICK_MIN);
    end else if (diff < 30'(TICK_MIN)) begin
      next_period = CNT_W'(TICK_MIN);
    end else begin
      next_period = CNT_W'(diff);
    end
  end

  assign period = period_q;

  logic unused_cfg;
  assign unused_cfg = ^bodyNum;
`else
  assign period = CNT_W'(TICK_DIV);

  logic unused_cfg;
  assign unused_cfg = ^{bodyNum, CNT_W'(TICK_STEP), CNT_W'(TICK_MIN)};
`endif

  assign start_edge = start_press & ~start_q;
  assign hit        = hitBody | hitWall;
  assign running    = (state_q == ST_PLAY) || (state_q == ST_DIE);
  assign tick       = running && (cnt_q == (period - CNT_W'(1)));
  assign eat        = (state_q == ST_PLAY) && valid_q && !hit &&
                      (headX == apple_x_q) && (headY == apple_y_q);
  assign apple_fits = ({1'b0, lfsr_q[5:0]}  < 7'(GRID_W)) &&
                      ({1'b0, lfsr_q[11:6]} < 7'(GRID_H));

  // Next-state logic for the sequencer, tick counter, apple and score
  always_comb begin
    state_d   = state_q;
    start_d   = start_press;
    cnt_d     = cnt_q;
    die_cnt_d = die_cnt_q;
    lfsr_d    = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
    valid_d   = valid_q;
    apple_x_d = apple_x_q;
    apple_y_d = apple_y_q;
    score_d   = score_q;
    move_d    = 1'b0;
    add_d     = 1'b0;
    flash_d   = flash_q;
`ifdef SNAKE_CTRL_SPEEDUP_EN
    period_d  = period_q;
    if (tick) begin
      period_d = next_period;
    end
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        move_d = tick;
        if (hit) begin
          state_d = ST_DIE;
        end
      end
      ST_DIE: begin
        if (tick) begin
          if (die_cnt_q == DIE_W'(DIE_TICKS - 1)) begin
            state_d = ST_OVER;
          end else begin
            die_cnt_d = die_cnt_q + DIE_W'(1);
            flash_d   = ~flash_q;
          end
        end
      end
      ST_OVER: begin
        if (start_edge) begin
          state_d = ST_IDLE;
          score_d = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter runs only in PLAY/DIE and restarts on every state change
    if (!running || (state_d != state_q) || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Blink and die-step count restart on any state change
    if (state_d != state_q) begin
      die_cnt_d = '0;
      flash_d   = 1'b0;
    end

    // Eat: grow pulse, saturating score, start relocating
    if (eat) begin
      add_d   = 1'b1;
      valid_d = 1'b0;
      if (score_q != 8'hFF) begin
        score_d = score_q + 8'd1;
      end
    end

    // Relocation by rejection sampling; old position kept until a hit
    if (!valid_q && apple_fits) begin
      apple_x_d = lfsr_q[5:0];
      apple_y_d = lfsr_q[11:6];
      valid_d   = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      die_cnt_q <= '0;
      lfsr_q    <= LFSR_SEED;
      valid_q   <= 1'b1;
      apple_x_q <= 6'(APPLE_X0);
      apple_y_q <= 6'(APPLE_Y0);
      score_q   <= 8'd0;
      move_q    <= 1'b0;
      add_q     <= 1'b0;
      flash_q   <= 1'b0;
`ifdef SNAKE_CTRL_SPEEDUP_EN
      period_q  <= CNT_W'(TICK_DIV);
`endif
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      die_cnt_q <= die_cnt_d;
      lfsr_q    <= lfsr_d;
      valid_q   <= valid_d;
      apple_x_q <= apple_x_d;
      apple_y_q <= apple_y_d;
      score_q   <= score_d;
      move_q    <= move_d;
      add_q     <= add_d;
      flash_q   <= flash_d;
`ifdef SNAKE_CTRL_SPEEDUP_EN
      period_q  <= period_d;
`endif
    end
  end

  assign gameStatus = state_q;
  assign moveTick   = move_q;
  assign addLength  = add_q;
  assign dieFlash   = flash_q;
  assign appleX     = apple_x_q;
  assign appleY     = apple_y_q;
  assign score      = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed vector table, hand-written sequences for
// DIE timing, OVER/IDLE start handling, hit-vs-eat, async reset and score
// saturation, then randomized play against a behavioural game model.
module tb_snake_game_ctrl;

  localparam int unsigned P  = 4;
  localparam int unsigned F  = 2;
  localparam int unsigned GW = 40;
  localparam int unsigned GH = 30;

  logic       clk;
  logic       rst;
  logic       start_press;
  logic [5:0] headX, headY;
  logic [6:0] bodyNum;
  logic       hitBody, hitWall;
  logic [1:0] gameStatus;
  logic       moveTick, addLength, dieFlash;
  logic [5:0] appleX, appleY;
  logic [7:0] score;

  int n_vec = 0;
  int n_bad = 0;

  snake_game_ctrl #(
    .TICK_DIV (P),
    .FLASH_CNT(F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_press(start_press),
    .headX      (headX),
    .headY      (headY),
    .bodyNum    (bodyNum),
    .hitBody    (hitBody),
    .hitWall    (hitWall),
    .gameStatus (gameStatus),
    .moveTick   (moveTick),
    .addLength  (addLength),
    .dieFlash   (dieFlash),
    .appleX     (appleX),
    .appleY     (appleY),
    .score      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural game model ----------------
  // phase: 0 idle, 1 play, 2 die, 3 over; m_k = cycles spent in phase
  int         m_phase;
  int         m_k;
  bit         m_prev_start;
  bit [11:0]  m_lfsr;
  bit         m_valid;
  logic [5:0] m_ax, m_ay;
  int         m_score;
  bit         m_move, m_add, m_flash;

  function automatic logic [1:0] phase_code(input int ph);
    case (ph)
      1:       return 2'b10;
      2:       return 2'b11;
      3:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_k = 0; m_prev_start = 1'b0; m_lfsr = 12'hACE;
    m_valid = 1'b1; m_ax = 6'd20; m_ay = 6'd15; m_score = 0;
    m_move = 1'b0; m_add = 1'b0; m_flash = 1'b0;
  endfunction

  function automatic void model_step();
    bit st_edge, hit, tick, eat;
    int nph;
    st_edge = start_press && !m_prev_start;
    hit     = hitBody || hitWall;
    tick    = (m_phase == 1 || m_phase == 2) && (((m_k + 1) % P) == 0);
    nph     = m_phase;
    case (m_phase)
      0: if (st_edge) nph = 1;
      1: if (hit) nph = 2;
      2: if (m_k + 1 == 2 * F * P) nph = 3;
      default: if (st_edge) nph = 0;
    endcase
    eat     = (m_phase == 1) && m_valid && !hit && headX == m_ax && headY == m_ay;
    m_move  = tick && (m_phase == 1);
    m_add   = eat;
    m_flash = (m_phase == 2 && nph == 2) ? ((((m_k + 1) / P) % 2) == 1) : 1'b0;
    if (m_phase == 3 && nph == 0) m_score = 0;
    else if (eat && m_score < 255) m_score = m_score + 1;
    if (!m_valid) begin
      if (int'(m_lfsr[5:0]) < GW && int'(m_lfsr[11:6]) < GH) begin
        m_ax = m_lfsr[5:0]; m_ay = m_lfsr[11:6]; m_valid = 1'b1;
      end
    end else if (eat) begin
      m_valid = 1'b0;
    end
    m_lfsr = {m_lfsr[10:0], m_lfsr[11] ^ m_lfsr[5] ^ m_lfsr[3] ^ m_lfsr[0]};
    m_k = (nph != m_phase) ? 0 : m_k + 1;
    m_phase = nph;
    m_prev_start = start_press;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("model gameStatus", 32'(gameStatus), 32'(phase_code(m_phase)));
    chk("model moveTick",   32'(moveTick),   32'(m_move));
    chk("model addLength",  32'(addLength),  32'(m_add));
    chk("model dieFlash",   32'(dieFlash),   32'(m_flash));
    chk("model appleX",     32'(appleX),     32'(m_ax));
    chk("model appleY",     32'(appleY),     32'(m_ay));
    chk("model score",      32'(score),      32'(m_score));
  endtask

  task automatic set_in(input logic st, input logic [5:0] hx, input logic [5:0] hy,
                        input logic hb, input logic hw);
    start_press = st; headX = hx; headY = hy; hitBody = hb; hitWall = hw;
  endtask

  // One clock: model follows the active edge, DUT checked on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_model();
  endtask

  // Called at a falling edge: async reset, checked before any clock edge
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("async rst gameStatus", 32'(gameStatus), 32'd0);
    chk("async rst dieFlash",   32'(dieFlash),   32'd0);
    chk("async rst addLength",  32'(addLength),  32'd0);
    chk("async rst moveTick",   32'(moveTick),   32'd0);
    chk("async rst appleX",     32'(appleX),     32'd20);
    chk("async rst appleY",     32'(appleY),     32'd15);
    chk("async rst score",      32'(score),      32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_apple();
    int n = 0;
    set_in(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    while (!m_valid && n < 200) begin
      cycle();
      n++;
    end
    chk("apple relocation within budget", 32'(n < 200), 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       st;
    logic [5:0] hx, hy;
    logic       hb, hw;
    logic [1:0] gs;
    logic       mt, al, df;
    logic [7:0] sc;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mkv(input logic st, input logic [5:0] hx, input logic [5:0] hy,
                               input logic hb, input logic hw, input logic [1:0] gs,
                               input logic mt, input logic al, input logic df,
                               input logic [7:0] sc);
    vec_t v;
    v.st = st; v.hx = hx; v.hy = hy; v.hb = hb; v.hw = hw;
    v.gs = gs; v.mt = mt; v.al = al; v.df = df; v.sc = sc;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic st;

    tbl[0]  = mkv(0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 0,  0,  0, 0, 2'b10, 0, 0, 0, 0);
    tbl[2]  = mkv(1, 0,  0,  0, 0, 2'b10, 0, 0, 0, 0);
    tbl[3]  = mkv(0, 0,  0,  0, 0, 2'b10, 0, 0, 0, 0);
    tbl[4]  = mkv(0, 0,  0,  0, 0, 2'b10, 0, 0, 0, 0);
    tbl[5]  = mkv(0, 0,  0,  0, 0, 2'b10, 1, 0, 0, 0);
    tbl[6]  = mkv(0, 20, 15, 0, 0, 2'b10, 0, 1, 0, 1);
    tbl[7]  = mkv(0, 20, 15, 0, 0, 2'b10, 0, 0, 0, 1);
    tbl[8]  = mkv(0, 0,  0,  0, 0, 2'b10, 0, 0, 0, 1);
    tbl[9]  = mkv(0, 0,  0,  0, 0, 2'b10, 1, 0, 0, 1);
    tbl[10] = mkv(0, 0,  0,  0, 1, 2'b11, 0, 0, 0, 1);

    rst = 1'b1; bodyNum = 7'd3;
    set_in(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset gameStatus", 32'(gameStatus), 32'd0);
    chk("reset appleX",     32'(appleX),     32'd20);
    chk("reset appleY",     32'(appleY),     32'd15);
    chk("reset score",      32'(score),      32'd0);
    chk("reset moveTick",   32'(moveTick),   32'd0);

    for (int i = 0; i < 11; i++) begin
      set_in(tbl[i].st, tbl[i].hx, tbl[i].hy, tbl[i].hb, tbl[i].hw);
      cycle();
      chk($sformatf("row%0d gameStatus", i), 32'(gameStatus), 32'(tbl[i].gs));
      chk($sformatf("row%0d moveTick", i),   32'(moveTick),   32'(tbl[i].mt));
      chk($sformatf("row%0d addLength", i),  32'(addLength),  32'(tbl[i].al));
      chk($sformatf("row%0d dieFlash", i),   32'(dieFlash),   32'(tbl[i].df));
      chk($sformatf("row%0d score", i),      32'(score),      32'(tbl[i].sc));
    end
    chk("relocated appleX range", 32'(appleX < 6'd40), 32'd1);
    chk("relocated appleY range", 32'(appleY < 6'd30), 32'd1);

    // DIE: blink every P cycles, OVER after 2*F*P cycles, hits ignored
    for (int i = 1; i <= 2 * F * P; i++) begin
      set_in(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
      cycle();
      chk($sformatf("die%0d gameStatus", i), 32'(gameStatus),
          (i < 2 * F * P) ? 32'd3 : 32'd1);
      chk($sformatf("die%0d dieFlash", i), 32'(dieFlash),
          (i < 2 * F * P) ? 32'((i / P) % 2) : 32'd0);
      chk($sformatf("die%0d moveTick", i), 32'(moveTick), 32'd0);
    end

    // OVER: held start goes to IDLE once and does not re-trigger PLAY
    set_in(1'b1, 6'd0, 6'd0, 1'b0, 1'b0);
    cycle();
    chk("over->idle gameStatus", 32'(gameStatus), 32'd0);
    chk("over->idle score",      32'(score),      32'd0);
    repeat (3) begin
      cycle();
      chk("held start stays idle", 32'(gameStatus), 32'd0);
    end
    set_in(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    cycle();
    set_in(1'b1, 6'd0, 6'd0, 1'b0, 1'b0);
    cycle();
    chk("new press -> play", 32'(gameStatus), 32'd2);

    // Eat once, then hit while standing on the apple: hit wins
    wait_apple();
    set_in(1'b0, m_ax, m_ay, 1'b0, 1'b0);
    cycle();
    chk("eat addLength", 32'(addLength), 32'd1);
    chk("eat score",     32'(score),     32'd1);
    wait_apple();
    set_in(1'b0, m_ax, m_ay, 1'b1, 1'b0);
    cycle();
    chk("hit+eat gameStatus", 32'(gameStatus), 32'd3);
    chk("hit+eat addLength",  32'(addLength),  32'd0);
    chk("hit+eat score",      32'(score),      32'd1);

    // Async reset in the middle of DIE while blinking
    set_in(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
    repeat (5) cycle();
    chk("mid-die flash on", 32'(dieFlash), 32'd1);
    do_reset();

    // Score saturation at 255
    set_in(1'b1, 6'd0, 6'd0, 1'b0, 1'b0);
    cycle();
    chk("sat play entry", 32'(gameStatus), 32'd2);
    n = 0;
    while (m_score < 255 && n < 8000) begin
      if (m_valid) set_in(1'b0, m_ax, m_ay, 1'b0, 1'b0);
      else         set_in(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
      cycle();
      n++;
    end
    chk("score reached 255", 32'(score), 32'd255);
    wait_apple();
    set_in(1'b0, m_ax, m_ay, 1'b0, 1'b0);
    cycle();
    chk("eat at 255 addLength", 32'(addLength), 32'd1);
    chk("eat at 255 score",     32'(score),     32'd255);

    // Randomized play against the model
    st = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) st = ~st;
      if (m_valid && $urandom_range(0, 2) == 0)
        set_in(st, m_ax, m_ay, ($urandom_range(0, 79) == 0), ($urandom_range(0, 79) == 0));
      else
        set_in(st, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
               ($urandom_range(0, 79) == 0), ($urandom_range(0, 79) == 0));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
